corefifo_reset_sequencer: RTL
=============================

// Module: corefifo_reset_sequencer
// PURPOSE
//  Downstream of the CoreFIFO reset synchronizer; consumes its synchronized active-low reset.
//  Sequences FIFO bring-up: holds FIFO pointer logic in reset, optionally zero-sweeps the
//  FIFO RAM, then asserts ready. Also services run-time flush requests with the same sequence.
//  Sits between the reset synchronizer and the arbiter's CoreFIFO/RAM instances.
// PARAMETERS
//  HOLD_CYCLES  8     cycles fifo_rst_n is held low before clear/ready; must be >= 1
//  DEPTH        1024  FIFO RAM words swept during clear; must be <= 2**ADDR_WIDTH
//  ADDR_WIDTH   10    RAM address width
//  CLEAR_MEM    1     1 = perform RAM zero-sweep; 0 = skip CLEAR state
// PORTS
//  clk           in   1           single clock
//  reset         in   1           async assert, active-low; deassert already synchronous to clk
//  flush_req     in   1           level; rising edge requests FIFO flush (honoured only when ready)
//  fifo_rst_n    out  1           active-low reset to FIFO pointer/flag logic, registered
//  mem_clr_we    out  1           RAM write enable during zero-sweep
//  mem_clr_addr  out  ADDR_WIDTH  RAM address during zero-sweep (write data is all-zero, external)
//  ready         out  1           FIFO usable; high only in READY
//  flush_ack     out  1           one-cycle pulse on completing a flush-initiated sequence
// BEHAVIOUR
//  - Reset (reset==0, async): state=HOLD, hold_cnt=0, flush_req_d=0, from_flush=0;
//    fifo_rst_n=0, mem_clr_we=0, mem_clr_addr=0, ready=0, flush_ack=0. All outputs registered.
//  - States: HOLD -> CLEAR (CLEAR_MEM=1) or READY (CLEAR_MEM=0); CLEAR -> READY; READY -> HOLD on flush.
//  - HOLD: fifo_rst_n=0, ready=0; hold_cnt counts 0..HOLD_CYCLES-1, one per edge; on edge with
//    hold_cnt==HOLD_CYCLES-1: leave HOLD, hold_cnt->0. HOLD lasts exactly HOLD_CYCLES edges.
//  - CLEAR: fifo_rst_n=0; mem_clr_we=1 with mem_clr_addr=0 on first CLEAR cycle, +1 per cycle;
//    on edge where mem_clr_addr==DEPTH-1 -> READY, mem_clr_we->0, mem_clr_addr->0.
//    Exactly DEPTH writes, no address skipped or repeated, no wrap past DEPTH-1.
//  - READY: fifo_rst_n=1, ready=1, mem_clr_we=0.
//  - Latency from first clk edge after reset deassert: ready=1 after HOLD_CYCLES+DEPTH edges
//    (CLEAR_MEM=1; 1032 at defaults) or HOLD_CYCLES edges (CLEAR_MEM=0). fifo_rst_n rises with ready.
//  - flush_req_d samples flush_req every cycle in every state; flush edge = flush_req & ~flush_req_d.
//  - Flush edge while in READY: next edge state=HOLD, ready=0, fifo_rst_n=0, from_flush=1.
//  - Flush edge in HOLD/CLEAR: ignored, not queued. flush_req held high across reset exit or
//    across sequence completion produces no edge in READY and no flush.
//  - flush_ack: pulses high for exactly one cycle, coincident with the first READY cycle, only
//    when from_flush=1; from_flush cleared at the same edge. Power-on/reset sequences give no ack.
//  - Reset asserted mid-HOLD/CLEAR/READY: immediate abort to reset values; sequence restarts
//    in HOLD after deassert. Pending from_flush is discarded (no flush_ack).
//  - hold_cnt width = max(1,$clog2(HOLD_CYCLES)); no arithmetic overflow at any parameter value.
// TESTING
//  T1 defaults, release reset -> fifo_rst_n=0 for 1032 edges, mem_clr_we high 1024 cycles
//     with addr 0..1023 in order, then ready=1/fifo_rst_n=1 at edge 1032, flush_ack stays 0.
//  T2 CLEAR_MEM=0, HOLD_CYCLES=3 -> ready=1 at edge 3, mem_clr_we never asserts.
//  T3 in READY, pulse flush_req 1 cycle -> ready=0 next edge, full resweep, flush_ack single
//     1-cycle pulse coincident with ready rising.
//  T4 flush_req rising during CLEAR (addr=500) -> ignored, ready at normal time, no flush_ack;
//     flush_req held high into READY -> no new flush.
//  T5 reset asserted at CLEAR addr=300 -> outputs to reset values asynchronously; after
//     deassert full sequence from HOLD, addr restarts at 0.
//  T6 flush in READY, then reset during resulting HOLD -> no flush_ack after reset recovery.

Source files
------------

// File: rtl/corefifo_reset_sequencer_if.sv
// Bring-up/flush handshake between the CoreFIFO reset sequencer and the FIFO/RAM it controls.
interface corefifo_reset_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  flush_req;
  logic                  fifo_rst_n;
  logic                  mem_clr_we;
  logic [ADDR_WIDTH-1:0] mem_clr_addr;
  logic                  ready;
  logic                  flush_ack;

  modport master (
    input  flush_req,
    output fifo_rst_n,
    output mem_clr_we,
    output mem_clr_addr,
    output ready,
    output flush_ack
  );

  modport slave (
    output flush_req,
    input  fifo_rst_n,
    input  mem_clr_we,
    input  mem_clr_addr,
    input  ready,
    input  flush_ack
  );
endinterface

// File: rtl/corefifo_reset_sequencer.sv
// Sequences CoreFIFO bring-up and flushes: hold pointer logic in reset, optionally
// zero-sweep the RAM, then raise ready (with a one-cycle ack when a flush started it).
module corefifo_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned CLEAR_MEM   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  corefifo_reset_sequencer_if.master  bus
);

  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]        HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]            state_q,        state_d;
  logic [HCW-1:0]        hold_cnt_q,     hold_cnt_d;
  logic                  flush_req_d_q;
  logic                  from_flush_q,   from_flush_d;
  logic                  fifo_rst_n_q,   fifo_rst_n_d;
  logic                  mem_clr_we_q,   mem_clr_we_d;
  logic [ADDR_WIDTH-1:0] mem_clr_addr_q, mem_clr_addr_d;
  logic                  ready_q,        ready_d;
  logic                  flush_ack_q,    flush_ack_d;
  logic                  flush_edge_c;
  logic                  enter_ready_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      flush_req_d_q  <= 1'b0;
      from_flush_q   <= 1'b0;
      fifo_rst_n_q   <= 1'b0;
      mem_clr_we_q   <= 1'b0;
      mem_clr_addr_q <= '0;
      ready_q        <= 1'b0;
      flush_ack_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      flush_req_d_q  <= bus.flush_req;
      from_flush_q   <= from_flush_d;
      fifo_rst_n_q   <= fifo_rst_n_d;
      mem_clr_we_q   <= mem_clr_we_d;
      mem_clr_addr_q <= mem_clr_addr_d;
      ready_q        <= ready_d;
      flush_ack_q    <= flush_ack_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    from_flush_d   = from_flush_q;
    fifo_rst_n_d   = 1'b0;
    mem_clr_we_d   = 1'b0;
    mem_clr_addr_d = '0;
    ready_d        = 1'b0;
    flush_ack_d    = 1'b0;
    enter_ready_c  = 1'b0;
    flush_edge_c   = bus.flush_req & ~flush_req_d_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (CLEAR_MEM != 0) begin
            state_d      = ST_CLEAR;
            mem_clr_we_d = 1'b1;
          end else begin
            enter_ready_c = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      ST_CLEAR: begin
        if (mem_clr_addr_q == ADDR_LAST) begin
          enter_ready_c = 1'b1;
        end else begin
          mem_clr_we_d   = 1'b1;
          mem_clr_addr_d = mem_clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        // Only a fresh rising edge seen while usable starts a flush
        if (flush_edge_c) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          from_flush_d = 1'b1;
        end else begin
          fifo_rst_n_d = 1'b1;
          ready_d      = 1'b1;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase

    if (enter_ready_c) begin
      state_d      = ST_READY;
      fifo_rst_n_d = 1'b1;
      ready_d      = 1'b1;
      flush_ack_d  = from_flush_q;
      from_flush_d = 1'b0;
    end
  end

  assign bus.fifo_rst_n   = fifo_rst_n_q;
  assign bus.mem_clr_we   = mem_clr_we_q;
  assign bus.mem_clr_addr = mem_clr_addr_q;
  assign bus.ready        = ready_q;
  assign bus.flush_ack    = flush_ack_q;

endmodule
